mux_scan_nx1: RTL and testbench

//  - Parametrised, registered N:1 multiplexer for WIDTH-bit channels.
//  - Two modes: manual (sel port picks the channel) or auto-scan (rotates through

---
 rtl/mux_scan_nx1.sv | 117 +++++++++++
 tb/tb_mux_scan_nx1.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1: registered N:1 mux, manual select or auto-scan with dwell.
// Define MUX_SCAN_MASK_EN to add a per-channel enable mask port.
module mux_scan_nx1 #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  localparam int SELW    = $clog2(CHANNELS),
  localparam int CW      = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      en,
`ifdef MUX_SCAN_MASK_EN
  input  logic [CHANNELS-1:0]       mask,
`endif
  output logic [WIDTH-1:0]          f,
  output logic [SELW-1:0]           ch,
  output logic                      valid,
  output logic                      wrap
);

  logic [WIDTH-1:0]    f_q, f_d;
  logic [SELW-1:0]     ch_q, ch_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                wrap_q, wrap_d;
  logic [CHANNELS-1:0] on;
  logic [SELW-1:0]     adv, nxt;
  logic                adv_wrap, found;
  logic                sel_ok, dwell_done;
  int                  idx;

`ifdef MUX_SCAN_MASK_EN
  assign on = mask;
`else
  assign on = '1;
`endif

  function automatic logic [WIDTH-1:0] lane(input logic [SELW-1:0] k);
    return din[int'(k)*WIDTH +: WIDTH];
  endfunction

  // next enabled channel above ch, wrapping; falls back to ch itself
  always_comb begin
    adv      = ch_q;
    adv_wrap = 1'b0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = int'(ch_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && on[SELW'(idx)]) begin
        found    = 1'b1;
        adv      = SELW'(idx);
        adv_wrap = (idx <= int'(ch_q));
      end
    end
  end

  assign sel_ok     = (int'(sel) < CHANNELS) && on[sel];
  assign dwell_done = !on[ch_q] || (cnt_q == CW'(DWELL - 1));

  always_comb begin
    f_d     = f_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    nxt     = ch_q;
    if (en && !mode) begin
      cnt_d = '0;
      if (sel_ok) begin
        f_d     = lane(sel);
        ch_d    = sel;
        valid_d = 1'b1;
      end else begin
        f_d = '0;
      end
    end else if (en && (|on)) begin
      if (dwell_done) begin
        nxt    = adv;
        wrap_d = adv_wrap;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      f_d     = lane(nxt);
      ch_d    = nxt;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q     <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      f_q     <= f_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign f     = f_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb_mux_scan_nx1: vectors, corner sequences and random stimulus
// against a behavioural model of the 4-channel scan mux.
module tb_mux_scan_nx1;

  localparam int DW = 4;
  localparam logic [31:0] DIN4 = 32'h33221100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [31:0] din4 = DIN4;
  logic [1:0]  sel4 = '0;
  logic        mode4 = 1'b0, en4 = 1'b0;
  logic [7:0]  f4;
  logic [1:0]  ch4;
  logic        valid4, wrap4;

  logic [23:0] din3 = 24'h221100;
  logic [1:0]  sel3 = '0;
  logic        mode3 = 1'b0, en3 = 1'b0;
  logic [7:0]  f3;
  logic [1:0]  ch3;
  logic        valid3, wrap3;

`ifdef MUX_SCAN_MASK_EN
  logic [3:0] mask4 = 4'hf;
  logic [2:0] mask3 = 3'h7;
`endif

  int checks = 0;
  int failures = 0;
  int m_f, m_ch, m_cnt;
  bit m_valid, m_wrap;

  typedef struct {
    logic [1:0] sel;
    int         f;
    int         ch;
    int         v;
  } vec_t;
  vec_t t1[4];

  always #5 clk = ~clk;

  mux_scan_nx1 #(.WIDTH(8), .CHANNELS(4), .DWELL(4)) u4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel4),
    .mode(mode4), .en(en4),
`ifdef MUX_SCAN_MASK_EN
    .mask(mask4),
`endif
    .f(f4), .ch(ch4), .valid(valid4), .wrap(wrap4)
  );

  mux_scan_nx1 #(.WIDTH(8), .CHANNELS(3), .DWELL(4)) u3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel3),
    .mode(mode3), .en(en3),
`ifdef MUX_SCAN_MASK_EN
    .mask(mask3),
`endif
    .f(f3), .ch(ch3), .valid(valid3), .wrap(wrap3)
  );

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit chan_on(int k);
`ifdef MUX_SCAN_MASK_EN
    return mask4[k];
`else
    return (k >= 0) && (k < 4);
`endif
  endfunction

  function automatic int lane(int k);
    return int'(din4[k*8 +: 8]);
  endfunction

  task automatic model_reset();
    m_f = 0; m_ch = 0; m_cnt = 0; m_valid = 0; m_wrap = 0;
  endtask

  // dwell counted as cycles already spent on the current channel
  task automatic model_step();
    int n;
    bit any;
    m_valid = 0;
    m_wrap = 0;
    if (!en4) return;
    if (!mode4) begin
      m_cnt = 0;
      if (chan_on(int'(sel4))) begin
        m_ch = int'(sel4);
        m_f = lane(m_ch);
        m_valid = 1;
      end else begin
        m_f = 0;
      end
      return;
    end
    any = 0;
    for (int k = 0; k < 4; k++) if (chan_on(k)) any = 1;
    if (!any) return;
    if (chan_on(m_ch) && m_cnt < DW - 1) begin
      m_cnt++;
    end else begin
      n = m_ch;
      do n = (n + 1) % 4; while (!chan_on(n));
      m_wrap = (n <= m_ch);
      m_ch = n;
      m_cnt = 0;
    end
    m_f = lane(m_ch);
    m_valid = 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("f", int'(f4), m_f);
    check("ch", int'(ch4), m_ch);
    check("valid", int'(valid4), int'(m_valid));
    check("wrap", int'(wrap4), int'(m_wrap));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst f", int'(f4), 0);
    check("rst ch", int'(ch4), 0);
    check("rst valid", int'(valid4), 0);
    check("rst wrap", int'(wrap4), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int saved;
    t1[0] = '{2'd0, 8'h00, 0, 1};
    t1[1] = '{2'd1, 8'h11, 1, 1};
    t1[2] = '{2'd2, 8'h22, 2, 1};
    t1[3] = '{2'd3, 8'h33, 3, 1};

    // manual select table
    do_reset();
    mode4 = 1'b0;
    en4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel4 = t1[i].sel;
      tick();
      check("t1 f", int'(f4), t1[i].f);
      check("t1 ch", int'(ch4), t1[i].ch);
      check("t1 valid", int'(valid4), t1[i].v);
    end

    // full auto-scan revolution
    do_reset();
    mode4 = 1'b1;
    en4 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("t2 ch", int'(ch4), (i / 4) % 4);
      check("t2 wrap", int'(wrap4), int'(i == 16));
    end

    // enable gap mid-dwell on channel 1
    do_reset();
    mode4 = 1'b1;
    en4 = 1'b1;
    repeat (5) tick();
    check("t3 ch before gap", int'(ch4), 1);
    en4 = 1'b0;
    din4 = 32'hdeadbeef;
    repeat (3) begin
      tick();
      check("t3 frozen f", int'(f4), 8'h11);
      check("t3 frozen valid", int'(valid4), 0);
    end
    din4 = DIN4;
    en4 = 1'b1;
    tick();
    tick();
    check("t3 dwell rest ch", int'(ch4), 1);
    tick();
    check("t3 advance ch", int'(ch4), 2);

    // three channels, out-of-range manual select
    do_reset();
    mode3 = 1'b0;
    en3 = 1'b1;
    sel3 = 2'd1;
    @(posedge clk); #1;
    check("t4 f sel1", int'(f3), 8'h11);
    check("t4 ch sel1", int'(ch3), 1);
    sel3 = 2'd3;
    @(posedge clk); #1;
    check("t4 f sel3", int'(f3), 0);
    check("t4 ch sel3", int'(ch3), 1);
    check("t4 valid sel3", int'(valid3), 0);
    sel3 = 2'd2;
    @(posedge clk); #1;
    check("t4 f sel2", int'(f3), 8'h22);
    check("t4 valid sel2", int'(valid3), 1);
    en3 = 1'b0;

    // async reset mid-dwell on channel 2
    do_reset();
    mode4 = 1'b1;
    en4 = 1'b1;
    repeat (9) tick();
    check("t5 ch pre", int'(ch4), 2);
    rst_n = 1'b0;
    model_reset();
    #2;
    check("t5 async f", int'(f4), 0);
    check("t5 async ch", int'(ch4), 0);
    check("t5 async valid", int'(valid4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t5 first ch", int'(ch4), 0);
    check("t5 first valid", int'(valid4), 1);

`ifdef MUX_SCAN_MASK_EN
    // masked scan over channels 1 and 3
    mask4 = 4'b1010;
    do_reset();
    mode4 = 1'b1;
    en4 = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("t6 ch", int'(ch4), (i <= 4) ? 1 : ((i <= 8) ? 3 : 1));
      check("t6 wrap", int'(wrap4), int'(i == 9));
    end
    saved = int'(f4);
    mask4 = 4'b0000;
    repeat (2) begin
      tick();
      check("t6 mask0 valid", int'(valid4), 0);
      check("t6 mask0 f", int'(f4), saved);
    end
    mask4 = 4'hf;
`endif

    // randomized traffic against the model
    do_reset();
    repeat (300) begin
      din4 = $urandom;
      mode4 = 1'($urandom_range(0, 1));
      en4 = ($urandom_range(0, 3) != 0);
      sel4 = 2'($urandom_range(0, 3));
`ifdef MUX_SCAN_MASK_EN
      mask4 = 4'($urandom_range(0, 15));
`endif
      tick();
    end

    saved = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
